// File: rtl/prewish5k_pkg.sv
// prewish5k_pkg: shared dispatcher state encoding and handshake constants for the mask loader
package prewish5k_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, STROBE = 2'b01, WAIT_ACK = 2'b11} disp_state_t;
  localparam bit ACK_PULSE = 1'b0;
  localparam bit ACK_HANDSHAKE = 1'b1;
  localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/prewish5k_mask_loader_if.sv
// prewish5k_mask_loader_if: update strobe bus from the mask loader to the mentor
interface prewish5k_mask_loader_if #(
  parameter int CH_W = 2,
  parameter int DATA_W = 8
);
  logic STB_O;
  logic [CH_W-1:0] ADR_O;
  logic [DATA_W-1:0] DAT_O;
  logic ACK_I;
  modport master(output STB_O, ADR_O, DAT_O, input ACK_I);
  modport slave(input STB_O, ADR_O, DAT_O, output ACK_I);
endinterface

// File: rtl/prewish5k_press_tracker.sv
// prewish5k_press_tracker: per-button press and long-hold detector with sticky pending flags
module prewish5k_press_tracker #(
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clear,
  output logic pend_load,
  output logic pend_clr
);
  logic armed, prev, press, long_hit;
  logic [23:0] hold_cnt;
  always_comb begin
    press = btn & ~prev & armed;
    long_hit = btn & armed & (LONG_PRESS_CYCLES != 24'd0) & (hold_cnt == LONG_PRESS_CYCLES - 24'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0; prev <= 1'b0; hold_cnt <= '0; pend_load <= 1'b0; pend_clr <= 1'b0;
    end else begin
      armed <= armed | ~btn;
      prev <= btn;
      hold_cnt <= !btn ? 24'd0 : (armed && hold_cnt != LONG_PRESS_CYCLES) ? hold_cnt + 24'd1 : hold_cnt;
      pend_load <= press | (pend_load & ~clear);
      pend_clr <= long_hit | (pend_clr & ~clear);
    end
  end
endmodule

// File: rtl/prewish5k_mask_loader.sv
// prewish5k_mask_loader: latches DIP values into per-button mask slots and announces each update
module prewish5k_mask_loader
  import prewish5k_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter bit DIP_ACTIVE_LOW = 1'b1,
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd12_000_000,
  parameter bit ACK_MODE = ACK_PULSE,
  parameter int ALIVE_BITS = 23
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [NUM_CH-1:0]        i_buttons,
  input  logic [DATA_W-1:0]        i_dip,
  prewish5k_mask_loader_if.master  bus,
  output logic [NUM_CH*DATA_W-1:0] o_masks,
  output logic                     o_busy,
  output logic                     o_alive
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  disp_state_t state, state_n;
  logic [NUM_CH-1:0] pend_load, pend_clr, pend, clear;
  logic [CH_W-1:0] sel;
  logic sel_clr, dispatch;
  logic [DATA_W-1:0] value;
  logic [ALIVE_BITS-1:0] alive;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_trk
    prewish5k_press_tracker #(.LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)) u_trk (
      .clk(CLK_I),
      .rst(RST_I),
      .btn(i_buttons[g]),
      .clear(clear[g]),
      .pend_load(pend_load[g]),
      .pend_clr(pend_clr[g])
    );
  end
  always_comb begin
    pend = pend_load | pend_clr;
    sel = '0;
    sel_clr = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) {sel, sel_clr} = pend[i] ? {CH_W'(i), pend_clr[i]} : {sel, sel_clr};
    dispatch = state == IDLE && |pend;
    clear = dispatch ? NUM_CH'(1) << sel : '0;
    value = sel_clr ? '0 : DIP_ACTIVE_LOW ? ~i_dip : i_dip;
    state_n = state == IDLE ? (dispatch ? (ACK_MODE == ACK_HANDSHAKE ? WAIT_ACK : STROBE) : IDLE)
            : (state == WAIT_ACK && !bus.ACK_I) ? WAIT_ACK : IDLE;
    bus.STB_O = state != IDLE;
    o_busy = (state != IDLE) | |pend;
    o_alive = alive[ALIVE_BITS-1];
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bus.ADR_O <= '0; bus.DAT_O <= '0; o_masks <= '0; alive <= '0;
    end else begin
      alive <= alive + ALIVE_BITS'(1);
      if (dispatch) begin
        bus.ADR_O <= sel; bus.DAT_O <= value; o_masks[sel*DATA_W +: DATA_W] <= value;
      end
    end
  end
endmodule
